// File: rtl/register_read_pkg.sv
// Shared constants, FSM state type and address helper for the register-file
// burst reader.
package register_read_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_t;

  // Register indices wrap modulo NUM_REGS (7 -> 0).
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return ADDR_W'(addr + 1'b1);
  endfunction

endpackage

// File: rtl/register32_burst_reader_mux8_32.sv
// Combinational 8:1 word select over the register file output buses.
module mux8_32
  import register_read_pkg::*;
(
  input  logic [ADDR_W-1:0] sel,
  input  logic [DATA_W-1:0] d_in0,
  input  logic [DATA_W-1:0] d_in1,
  input  logic [DATA_W-1:0] d_in2,
  input  logic [DATA_W-1:0] d_in3,
  input  logic [DATA_W-1:0] d_in4,
  input  logic [DATA_W-1:0] d_in5,
  input  logic [DATA_W-1:0] d_in6,
  input  logic [DATA_W-1:0] d_in7,
  output logic [DATA_W-1:0] q
);

  always_comb begin
    q = d_in0;
    case (sel)
      3'd0:    q = d_in0;
      3'd1:    q = d_in1;
      3'd2:    q = d_in2;
      3'd3:    q = d_in3;
      3'd4:    q = d_in4;
      3'd5:    q = d_in5;
      3'd6:    q = d_in6;
      3'd7:    q = d_in7;
      default: q = d_in0;
    endcase
  end

endmodule

// File: rtl/register32_burst_reader.sv
// Burst reader for the 8x32 register file: takes (start, count-1) commands and
// streams registered word snapshots over valid/ready with a last flag.
module register32_burst_reader
  import register_read_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] d_in0,
  input  logic [DATA_W-1:0] d_in1,
  input  logic [DATA_W-1:0] d_in2,
  input  logic [DATA_W-1:0] d_in3,
  input  logic [DATA_W-1:0] d_in4,
  input  logic [DATA_W-1:0] d_in5,
  input  logic [DATA_W-1:0] d_in6,
  input  logic [DATA_W-1:0] d_in7,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              busy
);

  rd_state_t         state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              accept;
  logic              handshake;

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign handshake = rd_valid && rd_ready;

  // In IDLE the first word comes straight from the command address; in RUN the
  // mux already looks one word ahead so a handshake can reload in the same edge.
  assign sel_addr = (state == IDLE) ? cmd_addr : next_addr(cur_addr);

  mux8_32 u_mux (
    .sel   (sel_addr),
    .d_in0 (d_in0),
    .d_in1 (d_in1),
    .d_in2 (d_in2),
    .d_in3 (d_in3),
    .d_in4 (d_in4),
    .d_in5 (d_in5),
    .d_in6 (d_in6),
    .d_in7 (d_in7),
    .q     (sel_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_addr   <= '0;
      rd_last   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RUN;
            busy      <= 1'b1;
            cur_addr  <= sel_addr;
            remaining <= cmd_len;
            rd_data   <= sel_data;
            rd_addr   <= sel_addr;
            rd_last   <= (cmd_len == '0);
            rd_valid  <= 1'b1;
          end
        end
        RUN: begin
          if (handshake) begin
            if (rd_last) begin
              // rd_data/rd_addr keep the final word for anyone still looking.
              state    <= IDLE;
              busy     <= 1'b0;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end else begin
              cur_addr  <= sel_addr;
              remaining <= ADDR_W'(remaining - 1'b1);
              rd_data   <= sel_data;
              rd_addr   <= sel_addr;
              rd_last   <= (remaining == ADDR_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register32_burst_reader.sv
// Scoreboard bench for register32_burst_reader: expected words are queued when
// a command is issued and checked by a monitor at every output handshake.
module tb_register32_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_addr;
  logic [2:0]  cmd_len;
  logic [31:0] din [8];
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [2:0]  rd_addr;
  logic        rd_last;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  addr;
    logic        last;
  } word_t;

  word_t exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register32_burst_reader dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .d_in0     (din[0]),
    .d_in1     (din[1]),
    .d_in2     (din[2]),
    .d_in3     (din[3]),
    .d_in4     (din[4]),
    .d_in5     (din[5]),
    .d_in6     (din[6]),
    .d_in7     (din[7]),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .rd_last   (rd_last),
    .busy      (busy)
  );

  // Monitor: a word handshakes on the coming rising edge if valid&&ready now.
  always @(negedge clk) begin
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      word_t got;
      word_t exp;
      got = '{data: rd_data, addr: rd_addr, last: rd_last};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got data=%h addr=%0d last=%0b required none", got.data, got.addr, got.last);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_word got data=%h addr=%0d last=%0b required data=%h addr=%0d last=%0b",
                   got.data, got.addr, got.last, exp.data, exp.addr, exp.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [2:0] addr, input logic [2:0] len);
    logic [2:0] a;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back('{data: din[a], addr: a, last: (i == int'(len))});
      a = a + 3'd1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_addr = 3'd5; cmd_len = 3'd2; rd_ready = 1'b1;
    tick(); tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h required 0", rd_data); end
    checks++; if (rd_addr !== 3'd0 || rd_last !== 1'b0) begin errors++; $display("FAIL reset_addr_last got %0d/%b required 0/0", rd_addr, rd_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready_in_reset got %b required 0", cmd_ready); end
    reset = 1'b0; cmd_valid = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready_after got %b required 1", cmd_ready); end
    tick();
    checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL reset_no_cmd got busy=%b valid=%b required 0/0", busy, rd_valid); end
  endtask

  task automatic test_single();
    din[3] = 32'hDEADBEEF; rd_ready = 1'b1;
    cmd_addr = 3'd3; cmd_len = 3'd0; cmd_valid = 1'b1;
    push_burst(3'd3, 3'd0);
    tick();
    cmd_valid = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF || rd_addr !== 3'd3 || rd_last !== 1'b1)
      begin errors++; $display("FAIL single_word got v=%b d=%h a=%0d l=%b required 1/deadbeef/3/1", rd_valid, rd_data, rd_addr, rd_last); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b required 1", busy); end
    tick();
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_end got v=%b busy=%b required 0/0", rd_valid, busy); end
    checks++; if (rd_data !== 32'hDEADBEEF || rd_addr !== 3'd3 || rd_last !== 1'b0)
      begin errors++; $display("FAIL single_hold got d=%h a=%0d l=%b required deadbeef/3/0", rd_data, rd_addr, rd_last); end
  endtask

  task automatic test_wrap();
    logic [2:0] a;
    for (int k = 0; k < 8; k++) din[k] = 32'h1000_0000 | k;
    rd_ready = 1'b1; cmd_addr = 3'd6; cmd_len = 3'd3; cmd_valid = 1'b1;
    push_burst(3'd6, 3'd3);
    tick();
    cmd_valid = 1'b0;
    a = 3'd6;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_addr !== a || rd_data !== (32'h1000_0000 | 32'(a)) || rd_last !== (i == 3))
        begin errors++; $display("FAIL wrap_word%0d got v=%b a=%0d d=%h l=%b required 1/%0d/%h/%b", i, rd_valid, rd_addr, rd_data, rd_last, a, 32'h1000_0000 | 32'(a), (i == 3)); end
      a = a + 3'd1;
      tick();
    end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL wrap_end got %b required 0", rd_valid); end
  endtask

  task automatic test_backpressure();
    din[2] = 32'hAAAA0000; din[3] = 32'h3333_0003;
    rd_ready = 1'b0; cmd_addr = 3'd2; cmd_len = 3'd1; cmd_valid = 1'b1;
    push_burst(3'd2, 3'd1);
    tick();
    cmd_valid = 1'b0;
    din[2] = 32'h5555FFFF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'hAAAA0000 || rd_addr !== 3'd2)
        begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h a=%0d required 1/aaaa0000/2", i, rd_valid, rd_data, rd_addr); end
      tick();
    end
    rd_ready = 1'b1;
    tick();
    checks++; if (rd_valid !== 1'b1 || rd_addr !== 3'd3 || rd_data !== 32'h3333_0003 || rd_last !== 1'b1)
      begin errors++; $display("FAIL bp_next got v=%b a=%0d d=%h l=%b required 1/3/33330003/1", rd_valid, rd_addr, rd_data, rd_last); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL bp_end got %b required 0", rd_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) din[k] = 32'hB000_0000 | k;
    rd_ready = 1'b1; cmd_addr = 3'd0; cmd_len = 3'd7; cmd_valid = 1'b1;
    push_burst(3'd0, 3'd7);
    push_burst(3'd5, 3'd1);
    tick();
    cmd_addr = 3'd5; cmd_len = 3'd1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cmd_ready !== 1'b0 || rd_addr !== 3'(i) || rd_valid !== 1'b1)
        begin errors++; $display("FAIL b2b_first%0d got rdy=%b a=%0d v=%b required 0/%0d/1", i, cmd_ready, rd_addr, rd_valid, i); end
      tick();
    end
    checks++; if (cmd_ready !== 1'b1 || rd_valid !== 1'b0)
      begin errors++; $display("FAIL b2b_bubble got rdy=%b v=%b required 1/0", cmd_ready, rd_valid); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_addr !== 3'd5 || rd_last !== 1'b0)
      begin errors++; $display("FAIL b2b_second0 got v=%b a=%0d l=%b required 1/5/0", rd_valid, rd_addr, rd_last); end
    tick();
    checks++; if (rd_valid !== 1'b1 || rd_addr !== 3'd6 || rd_last !== 1'b1)
      begin errors++; $display("FAIL b2b_second1 got v=%b a=%0d l=%b required 1/6/1", rd_valid, rd_addr, rd_last); end
    tick();
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end got v=%b busy=%b required 0/0", rd_valid, busy); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) din[k] = 32'hC000_0000 | k;
    rd_ready = 1'b1; cmd_addr = 3'd0; cmd_len = 3'd7; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{data: din[i], addr: 3'(i), last: 1'b0});
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    rd_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_last !== 1'b0 || rd_data !== 32'h0 || rd_addr !== 3'd0)
      begin errors++; $display("FAIL mid_reset got v=%b busy=%b l=%b d=%h a=%0d required all 0", rd_valid, busy, rd_last, rd_data, rd_addr); end
    rd_ready = 1'b1; cmd_addr = 3'd4; cmd_len = 3'd1; cmd_valid = 1'b1;
    push_burst(3'd4, 3'd1);
    tick();
    cmd_valid = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_addr !== 3'd4 || rd_data !== 32'hC000_0004)
      begin errors++; $display("FAIL mid_restart got v=%b a=%0d d=%h required 1/4/c0000004", rd_valid, rd_addr, rd_data); end
    tick();
    checks++; if (rd_addr !== 3'd5 || rd_last !== 1'b1) begin errors++; $display("FAIL mid_restart_last got a=%0d l=%b required 5/1", rd_addr, rd_last); end
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; rd_ready = 1'b0;
    for (int k = 0; k < 8; k++) din[k] = '0;
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register32_burst_reader.md
# register32_burst_reader

Read-side companion to the 8×32 register file. Accepts a read command (start address, word count), walks the register-file outputs with address wrap-around, and streams each word out over a valid/ready interface with a last flag. Each word is a registered snapshot taken when it is loaded into the output stage, so it stays stable under back-pressure even if the register file is written meanwhile. It sits between the register file's eight `d_out` buses and any consumer: debug dump, bus bridge or serializer.

## Interface
- `DATA_W`, 32: word width; must match the register file.
- `NUM_REGS`, 8: register count; fixed at 8.
- `ADDR_W`, 3: address width, log2(NUM_REGS).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block can accept a command.
- `cmd_addr` in 3: start register index.
- `cmd_len` in 3: word count minus 1 (0 → 1 word, 7 → 8 words).
- `d_in0` … `d_in7` in 32 each: register file outputs.
- `rd_valid` out 1: output word valid.
- `rd_ready` in 1: consumer accepts the word.
- `rd_data` out 32: snapshot word.
- `rd_addr` out 3: register index of `rd_data`.
- `rd_last` out 1: final word of the burst.
- `busy` out 1: burst in progress.

## Operation
- Reset values: FSM in IDLE, `rd_valid`=0, `rd_data`=0, `rd_addr`=0, `rd_last`=0, `busy`=0, internal counters=0.
- `cmd_ready` = (state==IDLE) && !reset.
- FSM states are IDLE and RUN.
- IDLE → RUN on `cmd_valid && cmd_ready`:
  - latch `cur_addr`=`cmd_addr` and `remaining`=`cmd_len`;
  - load the output stage from `cur_addr`.
- Output stage load:
  - `rd_data` ← d_in[`cur_addr`];
  - `rd_addr` ← `cur_addr`;
  - `rd_last` ← (`remaining`==0);
  - `rd_valid` ← 1.
- RUN, on a handshake (`rd_valid && rd_ready`):
  - if `rd_last`=1: go to IDLE, `rd_valid` ← 0, `rd_last` ← 0. `rd_data`/`rd_addr` hold their last values.
  - otherwise: `cur_addr` ← `cur_addr`+1 mod 8 (7 wraps to 0), `remaining` ← `remaining`−1, and the output stage loads the next word in the same edge.
- RUN with no handshake: all outputs hold.
  - `rd_data` must not track d_in changes.
  - `rd_valid` must not drop before a handshake.
- `busy` = (state==RUN), registered.
- A command presented while busy is not accepted. `cmd_valid` may stay high; it is taken in the first IDLE cycle.
- Arithmetic: address increment is 3-bit modulo. `remaining` never decrements below 0, because `rd_last` gates the decrement.

## Timing
- Command accept to first `rd_valid`=1: 1 cycle (registered output).
- Throughput: 1 word/cycle with `rd_ready` held high. An N-word burst occupies cycles 1…N after accept.
- Back-to-back bursts:
  - last handshake at edge k → IDLE;
  - `cmd_ready`=1 in cycle k+1;
  - next burst's first word valid at k+2.
  - One bubble cycle between bursts is required.
- Snapshot point: the value of d_in at the loading edge. A register-file write committing on that same edge is not seen, because the old value was on d_in.
- `reset` asserted mid-burst: on the next rising edge all outputs take their reset values and the in-flight burst is discarded. No partial `rd_last` is emitted.
- `reset` and `cmd_valid` in the same cycle: reset wins and the command is ignored.

## Structure
- Package `register_read_pkg` holds:
  - `DATA_W`=32, `NUM_REGS`=8, `ADDR_W`=3;
  - FSM state typedef `rd_state_t` {IDLE, RUN}.
- Sub-module `mux8_32`: combinational 8:1 32-bit select of d_in0..d_in7 by `cur_addr`. It feeds the output-stage load.
- Top module: FSM, address/remaining counters, output register.

## Test plan
- Reset behaviour: assert `reset` for 2 cycles with `cmd_valid`=1 → all outputs 0, no command taken, and `cmd_ready`=1 in the first cycle after release.
- Single word: d_in3=0xDEADBEEF, cmd addr=3, len=0, `rd_ready`=1 → one cycle later `rd_valid`=1, `rd_data`=0xDEADBEEF, `rd_addr`=3, `rd_last`=1; next cycle `rd_valid`=0 and `busy`=0.
- Wrap burst: d_inK=0x1000_000K, cmd addr=6, len=3, `rd_ready`=1 → addresses 6,7,0,1 on consecutive cycles, data 0x10000006, 0x10000007, 0x10000000, 0x10000001, `rd_last` only on address 1.
- Back-pressure snapshot: burst from addr 2; hold `rd_ready`=0 for 4 cycles while d_in2 changes 0xAAAA0000 → 0x5555FFFF → `rd_data` stays 0xAAAA0000, `rd_valid` stays 1, and the next word follows 1 cycle after `rd_ready` rises.
- Command while busy: 8-word burst from 0 with a second command (addr=5, len=1) held valid → second command accepted only in the cycle after the first burst's last handshake; its first word appears 2 cycles after that last handshake.
- Reset mid-burst: assert `reset` after the 3rd word of an 8-word burst → next cycle `rd_valid`=0 and `busy`=0; a new command then starts cleanly from its own `cmd_addr`.
